// File: rtl/types_pkg.sv
// Shared types and sizing for the rename stage: decode/rename packets and
// physical/architectural register widths.
package types_pkg;

  localparam int PREG_W        = 7;
  localparam int NUM_PREG      = 128;
  localparam int NUM_AREG      = 32;
  localparam int ROB_TAG_W     = 4;
  localparam int AREG_W        = 5;
  localparam int CNT_W         = PREG_W + 1;
  localparam int NUM_INIT_FREE = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [AREG_W-1:0]    areg_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic        fu_alu;
    logic        fu_mem;
    logic        fu_br;
    logic        has_rd;
  } decode_data;

  typedef struct packed {
    preg_t       pd_new;
    preg_t       pd_old;
    preg_t       ps1;
    preg_t       ps2;
    rob_tag_t    rob_tag;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        fu_alu;
    logic        fu_mem;
    logic        fu_br;
  } rename_data;

  // Writes to x0 are architecturally discarded, so they never consume a register.
  function automatic logic needs_alloc(input decode_data d);
    return d.has_rd && (d.rd != '0);
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers; head can be rewound to a
// checkpointed position to reclaim registers allocated on a wrong path.
module free_list
  import types_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  pop,
  input  logic  push,
  input  preg_t push_reg,
  input  logic  restore,
  input  preg_t restore_head,
  output preg_t head_reg,
  output preg_t head,
  output cnt_t  count,
  output logic  empty
);

  preg_t slots [NUM_PREG];
  preg_t tail;
  preg_t reclaimed;

  assign head_reg  = slots[head];
  assign empty     = (count == '0);
  assign reclaimed = head - restore_head;

  // Rewinding head returns every entry popped since the checkpoint; a retire
  // push in the same cycle still lands at the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        slots[i] <= (i < NUM_INIT_FREE) ? preg_t'(i + NUM_AREG) : '0;
      end
      head  <= '0;
      tail  <= preg_t'(NUM_INIT_FREE);
      count <= cnt_t'(NUM_INIT_FREE);
    end else begin
      if (push) begin
        slots[tail] <= push_reg;
        tail        <= tail + preg_t'(1);
      end
      if (restore) begin
        head  <= restore_head;
        count <= count + cnt_t'(reclaimed) + cnt_t'(push);
      end else begin
        head  <= head + preg_t'(pop);
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: map table lookup/update, free-list allocation,
// single branch checkpoint and a one-entry output register toward dispatch.
module rename_stage
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  decode_data data_in,
  output logic       ready_in,
  output logic       valid_out,
  output rename_data data_out,
  input  logic       ready_out,
  input  logic       retire_valid,
  input  preg_t      retire_pd_old,
  input  logic       mispredict,
  input  logic       branch_resolved
);

  preg_t      map_table [NUM_AREG];
  preg_t      map_post  [NUM_AREG];
  preg_t      ckpt_map  [NUM_AREG];
  preg_t      ckpt_head;
  rob_tag_t   ckpt_rob_tag;
  logic       ckpt_valid;
  rob_tag_t   rob_tag_cnt;

  logic       alloc_needed;
  logic       accept;
  logic       do_pop;
  logic       do_push;
  logic       do_restore;
  preg_t      fl_head_reg;
  preg_t      fl_head;
  cnt_t       fl_count;
  logic       fl_empty_unused;
  preg_t      ps1;
  preg_t      ps2;
  preg_t      pd_old;
  preg_t      pd_new;
  rename_data packet;

  assign alloc_needed = needs_alloc(data_in);
  assign ready_in     = (!valid_out || ready_out) && !mispredict
                        && (fl_count != '0 || !alloc_needed)
                        && !(data_in.fu_br && ckpt_valid);
  assign accept       = valid_in && ready_in;
  assign do_pop       = accept && alloc_needed;
  assign do_push      = retire_valid && (retire_pd_old != '0);
  assign do_restore   = mispredict && ckpt_valid;

  assign ps1    = (data_in.rs1 == '0) ? '0 : map_table[data_in.rs1];
  assign ps2    = (data_in.rs2 == '0) ? '0 : map_table[data_in.rs2];
  assign pd_old = alloc_needed ? map_table[data_in.rd] : '0;
  assign pd_new = alloc_needed ? fl_head_reg : '0;

  free_list u_free_list (
    .clk          (clk),
    .reset        (reset),
    .pop          (do_pop),
    .push         (do_push),
    .push_reg     (retire_pd_old),
    .restore      (do_restore),
    .restore_head (ckpt_head),
    .head_reg     (fl_head_reg),
    .head         (fl_head),
    .count        (fl_count),
    .empty        (fl_empty_unused)
  );

  // The map as it will look after this cycle's rename; a branch snapshots this
  // so its own destination survives a later rollback.
  always_comb begin
    map_post = map_table;
    if (do_pop) begin
      map_post[data_in.rd] = pd_new;
    end
  end

  always_comb begin
    packet         = '0;
    packet.pd_new  = pd_new;
    packet.pd_old  = pd_old;
    packet.ps1     = ps1;
    packet.ps2     = ps2;
    packet.rob_tag = rob_tag_cnt;
    packet.pc      = data_in.pc;
    packet.opcode  = data_in.opcode;
    packet.func3   = data_in.func3;
    packet.func7   = data_in.func7;
    packet.imm     = data_in.imm;
    packet.fu_alu  = data_in.fu_alu;
    packet.fu_mem  = data_in.fu_mem;
    packet.fu_br   = data_in.fu_br;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        map_table[i] <= preg_t'(i);
      end
    end else if (do_restore) begin
      map_table <= ckpt_map;
    end else begin
      map_table <= map_post;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && data_in.fu_br) begin
      ckpt_map <= map_post;
    end
  end

  // Mispredict outranks resolve; a new branch can only arrive with no
  // checkpoint outstanding, so setting and clearing never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      ckpt_valid   <= 1'b0;
      ckpt_head    <= '0;
      ckpt_rob_tag <= '0;
    end else if (mispredict) begin
      ckpt_valid <= 1'b0;
    end else if (accept && data_in.fu_br) begin
      ckpt_valid   <= 1'b1;
      ckpt_head    <= fl_head + preg_t'(do_pop);
      ckpt_rob_tag <= rob_tag_cnt + rob_tag_t'(1);
    end else if (branch_resolved) begin
      ckpt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rob_tag_cnt <= '0;
    end else if (do_restore) begin
      rob_tag_cnt <= ckpt_rob_tag;
    end else if (accept) begin
      rob_tag_cnt <= rob_tag_cnt + rob_tag_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (mispredict) begin
      valid_out <= 1'b0;
    end else if (accept) begin
      valid_out <= 1'b1;
      data_out  <= packet;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 valid_in  in  1  decoded instruction present from decode.
REQ-004 data_in  in  decode_data  pc, Opcode, func3, func7, imm, rs1, rs2, rd (5b each), fu_alu, fu_mem, fu_br, has_rd.
REQ-005 ready_in  out  1  stage accepts data_in this cycle.
REQ-006 valid_out  out  1  renamed instruction held for dispatch.
REQ-007 data_out  out  rename_data  renamed packet: pd_new, pd_old, ps1, ps2 (7b each), rob_tag, pc, Opcode, func3, func7, imm, fu_* flags.
REQ-008 ready_out  in  1  dispatch accepts data_out this cycle.
REQ-009 retire_valid  in  1  ROB retires an instruction this cycle.
REQ-010 retire_pd_old  in  7  stale physical register to return to the free list.
REQ-011 mispredict  in  1  flush and restore to the branch checkpoint.
REQ-012 branch_resolved  in  1  outstanding branch resolved correctly; release the checkpoint.

Function
REQ-013 A 32x7 map table SHALL hold the speculative architectural-to-physical mapping; arch x0 SHALL always read p0.
REQ-014 A free list of physical registers SHALL be a 128-entry circular FIFO with 7-bit head, 7-bit tail and 8-bit count.
REQ-015 Acceptance condition: valid_in && ready_in; ready_in = (!valid_out || ready_out) && !flush_this_cycle && (count!=0 || !alloc_needed) && !(fu_br && ckpt_valid).
REQ-016 alloc_needed = has_rd && rd!=0; on acceptance with alloc_needed, pd_new = free_list[head], head+1 (mod 128), count-1, map[rd] <= pd_new.
REQ-017 With !alloc_needed: pd_new=0, pd_old=0, no free-list or map change.
REQ-018 ps1/ps2 SHALL read the map table combinationally; pd_old = map[rd] before the update.
REQ-019 rob_tag SHALL come from a 4-bit counter that increments on each acceptance and wraps 15->0.
REQ-020 Output register: latency one cycle from acceptance to valid_out; data_out SHALL hold stable while valid_out && !ready_out.
REQ-021 On retire_valid with retire_pd_old!=0: free_list[tail] <= retire_pd_old, tail+1, count+1; pd_old==0 SHALL be ignored.
REQ-022 Simultaneous allocate and free: head and tail both advance; count unchanged.
REQ-023 On accepting a branch (fu_br): snapshot the post-rename map table, head, and rob_tag counter+1; set ckpt_valid.
REQ-024 While ckpt_valid, a second branch SHALL stall (ready_in=0) until branch_resolved or mispredict.
REQ-025 On branch_resolved: clear ckpt_valid.
REQ-026 On mispredict: restore map, head and rob_tag counter from the checkpoint; count += (current head - checkpoint head) mod 128; same-cycle retire push still applies; clear valid_out; clear ckpt_valid; accept nothing.
REQ-027 mispredict together with branch_resolved: mispredict SHALL take priority.
REQ-028 mispredict with ckpt_valid=0: clear valid_out only; map and free list unchanged.

Reset
REQ-029 On reset: map[i]=i for i=0..31; free_list holds p32..p127 in order, head=0, tail=96, count=96.
REQ-030 On reset: valid_out=0, data_out='0, ckpt_valid=0, rob_tag counter=0; ready_in SHALL be 1 in the first cycle after reset deassertion.
REQ-031 Reset asserted mid-operation SHALL override retire, mispredict and acceptance in the same cycle.

Structure
REQ-032 decode_data, rename_data, PREG_W=7, NUM_PREG=128, NUM_AREG=32 and ROB_TAG_W=4 SHALL reside in types_pkg.
REQ-033 The free list SHALL be a sub-module free_list (pop, push, head-restore ports, count/empty outputs); map table and checkpoint SHALL remain in rename_stage.

Verification
REQ-034 After reset, add x5 (rd=5,rs1=1,rs2=2) -> next cycle valid_out=1, pd_new=32, pd_old=5, ps1=1, ps2=2, rob_tag=0.
REQ-035 Rename 96 writers with no retire -> count=0, ready_in=0 for the 97th writer; a non-writer (has_rd=0) still accepted with pd_new=0.
REQ-036 Hold ready_out=0 for 3 cycles with valid_out=1 -> data_out unchanged, ready_in=0, no allocation.
REQ-037 Branch then writes to x7 (p33) and x8 (p34), then mispredict -> map[7]=7, map[8]=8, next allocation=p33, rob_tag restored to 1.
REQ-038 Same-cycle accept (rd=3) and retire_pd_old=40 -> count unchanged, p40 at old tail; retire_pd_old=0 -> count unchanged.
REQ-039 Second branch while ckpt_valid -> stalled; branch_resolved pulse -> accepted the next cycle.
